// File: rtl/execute_stage.sv
// execute_stage: computes val2 and the ALU result, holds NZCV, resolves branches
// and latches results into the EX/MEM register.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_freeze,
    input  logic        i_wb_en,
    input  logic        i_mem_r_en,
    input  logic        i_mem_w_en,
    input  logic        i_b,
    input  logic        i_s,
    input  logic [3:0]  i_exec_cmd,
    input  logic [31:0] i_val_rn,
    input  logic [31:0] i_val_rm,
    input  logic        i_imm,
    input  logic [11:0] i_shift_operand,
    input  logic [23:0] i_signed_imm_24,
    input  logic [3:0]  i_dest,
    input  logic [31:0] i_pc_in,
    output logic        o_wb_en_out,
    output logic        o_mem_r_en_out,
    output logic        o_mem_w_en_out,
    output logic [31:0] o_alu_result,
    output logic [31:0] o_val_rm_out,
    output logic [3:0]  o_dest_out,
    output logic [3:0]  o_sr,
    output logic        o_branch_taken,
    output logic [31:0] o_branch_address
);
    logic [4:0]  w_shamt;
    logic [4:0]  w_rot;
    logic [63:0] w_imm_ror;
    logic [63:0] w_rm_ror;
    logic [31:0] w_shifted;
    logic [31:0] w_val2;
    logic        w_sub;
    logic        w_arith;
    logic        w_cin;
    logic [31:0] w_op2;
    logic [32:0] w_sum;
    logic [31:0] w_result;
    logic        w_c;
    logic        w_v;
    logic [3:0]  r_sr;

    assign w_shamt   = i_shift_operand[11:7];
    assign w_rot     = {i_shift_operand[11:8], 1'b0};
    assign w_imm_ror = {2{24'b0, i_shift_operand[7:0]}} >> w_rot;
    assign w_rm_ror  = {2{i_val_rm}} >> w_shamt;

    always_comb begin
        case (i_shift_operand[6:5])
            2'b00:   w_shifted = i_val_rm << w_shamt;
            2'b01:   w_shifted = i_val_rm >> w_shamt;
            2'b10:   w_shifted = $signed(i_val_rm) >>> w_shamt;
            default: w_shifted = w_rm_ror[31:0];
        endcase
    end

    assign w_val2 = (i_mem_r_en | i_mem_w_en) ? {20'b0, i_shift_operand} :
                    i_imm ? w_imm_ror[31:0] : w_shifted;

    // One adder serves ADD/ADC/SUB/SBC; subtract forms feed ~val2.
    assign w_arith = i_exec_cmd inside {4'b0010, 4'b0011, 4'b0100, 4'b0101};
    assign w_sub   = i_exec_cmd inside {4'b0100, 4'b0101};
    assign w_cin   = (i_exec_cmd == 4'b0100) ? 1'b1 :
                     (i_exec_cmd inside {4'b0011, 4'b0101}) ? r_sr[1] : 1'b0;
    assign w_op2   = w_sub ? ~w_val2 : w_val2;
    assign w_sum   = {1'b0, i_val_rn} + {1'b0, w_op2} + {32'b0, w_cin};

    always_comb begin
        case (i_exec_cmd)
            4'b0001: w_result = w_val2;
            4'b1001: w_result = ~w_val2;
            4'b0010, 4'b0011, 4'b0100, 4'b0101: w_result = w_sum[31:0];
            4'b0110: w_result = i_val_rn & w_val2;
            4'b0111: w_result = i_val_rn | w_val2;
            4'b1000: w_result = i_val_rn ^ w_val2;
            default: w_result = 32'b0;
        endcase
    end

    assign w_c = w_arith ? w_sum[32] : r_sr[1];
    assign w_v = w_arith ? ((i_val_rn[31] == w_op2[31]) && (w_sum[31] != i_val_rn[31])) : r_sr[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr           <= 4'b0;
            o_wb_en_out    <= 1'b0;
            o_mem_r_en_out <= 1'b0;
            o_mem_w_en_out <= 1'b0;
            o_alu_result   <= 32'b0;
            o_val_rm_out   <= 32'b0;
            o_dest_out     <= 4'b0;
        end else if (!i_freeze) begin
            if (i_s)
                r_sr <= {w_result[31], w_result == 32'b0, w_c, w_v};
            o_wb_en_out    <= i_wb_en;
            o_mem_r_en_out <= i_mem_r_en;
            o_mem_w_en_out <= i_mem_w_en;
            o_alu_result   <= w_result;
            o_val_rm_out   <= i_val_rm;
            o_dest_out     <= i_dest;
        end
    end

    assign o_sr             = r_sr;
    assign o_branch_taken   = i_b;
    assign o_branch_address = i_pc_in + {{6{i_signed_imm_24[23]}}, i_signed_imm_24, 2'b00};
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed plus random checks of execute_stage against an
// arithmetic reference model of the operand, ALU and flag rules.
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst, freeze, wb_en, mem_r_en, mem_w_en, b, s, imm;
    logic [3:0]  exec_cmd, dest;
    logic [31:0] val_rn, val_rm, pc_in;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out, branch_taken;
    logic [31:0] alu_result, val_rm_out, branch_address;
    logic [3:0]  dest_out, sr;

    logic        e_wb, e_mr, e_mw;
    logic [31:0] e_alu, e_rm;
    logic [3:0]  e_dest, e_sr;
    int          vectors = 0;
    int          miscompares = 0;

    execute_stage dut (
        .clk(clk), .rst(rst), .i_freeze(freeze), .i_wb_en(wb_en), .i_mem_r_en(mem_r_en),
        .i_mem_w_en(mem_w_en), .i_b(b), .i_s(s), .i_exec_cmd(exec_cmd), .i_val_rn(val_rn),
        .i_val_rm(val_rm), .i_imm(imm), .i_shift_operand(shift_operand),
        .i_signed_imm_24(signed_imm_24), .i_dest(dest), .i_pc_in(pc_in),
        .o_wb_en_out(wb_en_out), .o_mem_r_en_out(mem_r_en_out), .o_mem_w_en_out(mem_w_en_out),
        .o_alu_result(alu_result), .o_val_rm_out(val_rm_out), .o_dest_out(dest_out),
        .o_sr(sr), .o_branch_taken(branch_taken), .o_branch_address(branch_address)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror1(input logic [31:0] x, input int n);
        logic [31:0] y = x;
        for (int i = 0; i < n; i++) y = {y[0], y[31:1]};
        return y;
    endfunction

    function automatic logic [31:0] m_val2();
        logic [63:0] ext;
        int          n = int'(shift_operand[11:7]);
        if (mem_r_en || mem_w_en) return {20'b0, shift_operand};
        if (imm) return ror1({24'b0, shift_operand[7:0]}, 2 * int'(shift_operand[11:8]));
        ext = {{32{val_rm[31]}}, val_rm};
        case (shift_operand[6:5])
            2'b00:   return val_rm << n;
            2'b01:   return val_rm >> n;
            2'b10:   return 32'(ext >> n);
            default: return ror1(val_rm, n);
        endcase
    endfunction

    // Computes the model's next EX/MEM and status contents from the current inputs.
    task automatic model_edge();
        logic [31:0] v2, op2, res;
        logic [63:0] u;
        longint      sv;
        logic        cin, arith, c, v;
        v2    = m_val2();
        arith = exec_cmd >= 4'd2 && exec_cmd <= 4'd5;
        op2   = (exec_cmd == 4'd4 || exec_cmd == 4'd5) ? ~v2 : v2;
        cin   = (exec_cmd == 4'd4) ? 1'b1 : (exec_cmd == 4'd3 || exec_cmd == 4'd5) ? e_sr[1] : 1'b0;
        u     = 64'(val_rn) + 64'(op2) + 64'(cin);
        sv    = longint'($signed(val_rn)) + longint'($signed(op2)) + longint'(cin);
        case (exec_cmd)
            4'd1:    res = v2;
            4'd9:    res = ~v2;
            4'd2, 4'd3, 4'd4, 4'd5: res = u[31:0];
            4'd6:    res = val_rn & v2;
            4'd7:    res = val_rn | v2;
            4'd8:    res = val_rn ^ v2;
            default: res = 32'd0;
        endcase
        c = arith ? u[32] : e_sr[1];
        v = arith ? (sv > 64'sd2147483647 || sv < -64'sd2147483648) : e_sr[0];
        if (rst) begin
            {e_wb, e_mr, e_mw, e_alu, e_rm, e_dest, e_sr} = '0;
        end else if (!freeze) begin
            if (s) e_sr = {res[31], res == 32'd0, c, v};
            {e_wb, e_mr, e_mw, e_alu, e_rm, e_dest} = {wb_en, mem_r_en, mem_w_en, res, val_rm, dest};
        end
    endtask

    task automatic tick();
        logic [31:0] ba;
        #1;
        ba = pc_in + 32'(longint'($signed(signed_imm_24)) * 4);
        chk("branch_taken", {31'b0, branch_taken}, {31'b0, b});
        chk("branch_address", branch_address, ba);
        model_edge();
        @(posedge clk);
        #1;
        chk("alu_result", alu_result, e_alu);
        chk("val_rm_out", val_rm_out, e_rm);
        chk("dest_out", {28'b0, dest_out}, {28'b0, e_dest});
        chk("ctrl_out", {29'b0, wb_en_out, mem_r_en_out, mem_w_en_out}, {29'b0, e_wb, e_mr, e_mw});
        chk("sr", {28'b0, sr}, {28'b0, e_sr});
    endtask

    task automatic set(input logic r, input logic fz, input logic [3:0] cmd, input logic ss,
                       input logic [31:0] rn, input logic [31:0] rm, input logic im,
                       input logic [11:0] so);
        {rst, freeze, exec_cmd, s, val_rn, val_rm, imm, shift_operand} = {r, fz, cmd, ss, rn, rm, im, so};
        {wb_en, mem_r_en, mem_w_en, b} = {cmd != 4'd0, 3'b000};
        dest = 4'd3; pc_in = 32'h40; signed_imm_24 = 24'h1;
    endtask

    initial begin
        {e_wb, e_mr, e_mw, e_alu, e_rm, e_dest, e_sr} = '0;
        @(negedge clk);
        set(1, 1, 4'd2, 1, 32'h5, 32'h6, 0, 12'h0);
        tick(); tick();
        chk("reset_alu", alu_result, 32'h0);
        chk("reset_sr", {28'b0, sr}, 32'h0);
        set(0, 0, 4'd2, 1, 32'hFFFFFFFF, 32'h1, 0, 12'h0); tick();
        chk("add_res", alu_result, 32'h0);
        chk("add_sr", {28'b0, sr}, 32'h6);
        set(0, 0, 4'd3, 0, 32'h1, 32'h1, 0, 12'h0); tick();
        chk("adc_res", alu_result, 32'h3);
        set(0, 0, 4'd4, 1, 32'h80000000, 32'h1, 0, 12'h0); tick();
        chk("sub_res", alu_result, 32'h7FFFFFFF);
        chk("sub_sr", {28'b0, sr}, 32'h3);
        set(0, 0, 4'd1, 0, 32'h0, 32'h0, 1, 12'h2FF); tick();
        chk("imm_rot", alu_result, 32'hF000000F);
        set(0, 0, 4'd1, 0, 32'h0, 32'h80000000, 0, 12'h240); tick();
        chk("asr4", alu_result, 32'hF8000000);
        set(0, 0, 4'd2, 0, 32'h100, 32'h77, 0, 12'hABC); mem_r_en = 1; tick();
        chk("mem_addr", alu_result, 32'hBBC);
        chk("mem_r_out", {31'b0, mem_r_en_out}, 32'h1);
        set(0, 0, 4'd0, 0, 32'h0, 32'h0, 0, 12'h0);
        {b, pc_in, signed_imm_24} = {1'b1, 32'h20, 24'hFFFFFE};
        #1;
        chk("br_addr", branch_address, 32'h18);
        chk("br_taken", {31'b0, branch_taken}, 32'h1);
        tick();
        for (int i = 0; i < 3; i++) begin
            set(0, 1, 4'd2, 1, $urandom, $urandom, 0, 12'h0); tick();
            chk("frz_dest", {28'b0, dest_out}, {28'b0, e_dest});
        end
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 40) == 0);
            freeze = ($urandom_range(0, 5) == 0);
            {wb_en, mem_r_en, mem_w_en, b, s, imm} = 6'($urandom);
            if ($urandom_range(0, 2) != 0) {mem_r_en, mem_w_en} = 2'b00;
            exec_cmd = 4'($urandom);
            val_rn = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF + 32'($urandom_range(0, 2)) : $urandom;
            val_rm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            shift_operand = 12'($urandom);
            signed_imm_24 = 24'($urandom);
            dest = 4'($urandom);
            pc_in = $urandom;
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage ARM pipeline. Sits directly downstream of instruction decode: it consumes the decoded control bits, register operands and shift operand, and computes the second operand (val2) and the ALU result. It holds the NZCV status register that decode reads for condition checks. It resolves branches and latches results into the EX/MEM pipeline register for the memory stage.

## Interface
Parameters: none; the datapath is fixed at 32 bits.

- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- freeze  in  1  memory-side stall; holds the EX/MEM register and the status register
- wb_en, mem_r_en, mem_w_en, b, s  in  1 each  decoded controls; all are already 0 for squashed instructions
- exec_cmd  in  4  ALU command
- val_rn, val_rm  in  32 each  register operands
- imm  in  1  immediate-operand flag (instruction bit 25)
- shift_operand  in  12  instruction[11:0]
- signed_imm_24  in  24  branch offset
- dest  in  4  destination register
- pc_in  in  32  PC+4 of this instruction
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  registered controls
- alu_result  out  32  registered result, or effective address for LDR/STR
- val_rm_out  out  32  registered store data
- dest_out  out  4  registered destination
- sr  out  4  status register {N,Z,C,V}, registered
- branch_taken  out  1  combinational; equals b
- branch_address  out  32  combinational; pc_in + (sign_extend(signed_imm_24) << 2), computed modulo 2^32

## Operation
- val2 selection, first match wins:
  - mem_r_en|mem_w_en: {20'b0, shift_operand}.
  - imm: {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
  - Otherwise: val_rm shifted by shift_operand[11:7] with type shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR). A shift amount of 0 passes val_rm unchanged. Bit 4 is ignored; register-specified shifts are unsupported.
- exec_cmd, with Cin = sr[1]:
  - 0001 MOV: result = val2.
  - 1001 MVN: result = ~val2.
  - 0010 ADD: result = rn+val2.
  - 0011 ADC: result = rn+val2+Cin.
  - 0100 SUB/CMP: result = rn+~val2+1.
  - 0101 SBC: result = rn+~val2+Cin.
  - 0110 AND/TST: result = rn&val2.
  - 0111 ORR: result = rn|val2.
  - 1000 EOR: result = rn^val2.
  - 0000 and all other codes: result = 0.
- Flags:
  - N = result[31].
  - Z = (result == 0).
  - Arithmetic codes (0010–0101): C = bit 32 of the 33-bit sum. V = the two sum operands have the same sign and the result sign differs; for the subtract forms the second operand is ~val2.
  - All other codes: C and V keep their current sr values.
- The status register loads the new flags on the clock edge when s=1 and freeze=0; otherwise it holds.
- The EX/MEM register loads wb_en, mem_r_en, mem_w_en, result, val_rm and dest on each edge when freeze=0.
- Branches: branch_taken = b, with no condition check (decode has already applied it). The upstream IF/ID and ID/EX flush is driven from branch_taken. A branch instruction itself enters EX/MEM with wb_en=0 and mem enables 0.

## Timing
- Reset (rst=1 at an edge): all registered outputs and sr go to 0. Reset takes priority over freeze.
- Latency: inputs are sampled at edge k; alu_result, the control outputs and sr are valid after edge k. Decode sees the updated sr on the instruction that follows.
- branch_taken and branch_address have zero cycles of latency: they are combinational from the current inputs.
- freeze=1: EX/MEM outputs and sr hold their values, even if s=1. branch outputs still follow the inputs combinationally.
- Squashed instruction (all controls 0, exec_cmd 0000): EX/MEM loads a bubble of zeros; sr is unchanged.
- Wrap-around: all adds are modulo 2^32. Carry/overflow are reported only through sr.

## Test plan
- Reset: assert rst for 2 cycles with freeze=1 and s=1 -> all outputs 0, sr=0000.
- Add with carry flags: ADD with s=1, rn=0xFFFFFFFF, val_rm=1, imm=0, shift 0 -> alu_result=0 and sr=0110 one cycle later. Next, ADC with rn=1, rm=1 -> result 3.
- Subtract overflow: SUB with s=1, rn=0x80000000, rm=1 -> result 0x7FFFFFFF and sr=0011.
- Immediate rotate: MOV with imm=1 and shift_operand=0x2FF (0xFF ROR 4) -> 0xF000000F. Next, a non-immediate ASR by 4 with rm=0x80000000 -> 0xF8000000.
- Memory address: mem_r_en=1, imm=0, shift_operand=0xABC, rn=0x100 -> alu_result=0xBBC and mem_r_en_out=1.
- Branch and freeze:
  - b=1, pc_in=0x20, signed_imm_24=0xFFFFFE -> branch_address=0x18 with branch_taken=1 in the same cycle.
  - With freeze=1 held for 3 cycles while ADD inputs change and s=1 -> outputs and sr are unchanged.
